scan_slot_scheduler: RTL and testbench
======================================

Name: scan_slot_scheduler

Overview:
- Runs one sensing-and-uplink cycle each time the downlink command FSM enters its scan state.
- Powers the sensor front-end for a fixed settle time, then requests one ADC sample.
- Waits a TDMA slot offset derived from the node address, so nodes sharing the backscatter channel do not collide.
- Serialises a preamble plus the sample onto the modulation output.
- Sits between the command FSM (scan trigger, latched address) and the sensor/backscatter front-end.

Parameters:
- SETTLE_CYCLES, 16: cycles sense_en is held before sampling (>=1).
- SAMPLE_TIMEOUT, 64: maximum cycles in SAMPLE waiting for sample_valid (>=1).
- SLOT_CYCLES, 32: cycles per TDMA slot.
- ID_WIDTH, 4: node address width.
- NBITS, 8: sample width.
- BIT_CYCLES, 4: cycles each uplink symbol is held (>=1).

Ports:
- CLK_IN  in  1  system clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- scan_start  in  1  one-cycle pulse from the command FSM on entry to its scan state.
- node_id  in  ID_WIDTH  node address from the command FSM data storage.
- abort  in  1  cancel the current cycle (FSM reset or timeout).
- sample_data  in  NBITS  ADC result.
- sample_valid  in  1  sample_data valid this cycle.
- sense_en  out  1  front-end power/bias enable.
- sample_req  out  1  ADC conversion request.
- mod_out  out  1  backscatter modulation bit.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse when uplink completes.
- error  out  1  sticky sample-timeout flag.

Behaviour:
- Clock and reset: one clock, CLK_IN. Reset is asynchronous and active-low on rst_n.
- Reset values: state=IDLE; sense_en, sample_req, mod_out, busy, done, error all 0; all counters and shift register 0.
- States: IDLE, SETTLE, SAMPLE, SLOT_WAIT, TX, DONE. All outputs are registered and are Moore with respect to the state register.
- IDLE:
  - Outputs low.
  - scan_start=1 at edge E0: latch node_id, clear error, go to SETTLE.
  - sense_en=1 and busy=1 from E0.
- SETTLE:
  - sense_en=1 for exactly SETTLE_CYCLES cycles.
  - Go to SAMPLE at edge E0+SETTLE_CYCLES.
- SAMPLE:
  - sense_en=1 and sample_req=1.
  - sample_valid=1 at an edge: capture sample_data into the shift register, go to SLOT_WAIT. sense_en and sample_req fall at that edge.
  - No sample_valid within SAMPLE_TIMEOUT cycles: set error=1, go to IDLE, no done pulse.
- SLOT_WAIT:
  - All outputs low except busy.
  - Lasts max(1, latched_id*SLOT_CYCLES) cycles, then TX.
  - Slot counter width is ID_WIDTH+clog2(SLOT_CYCLES+1); no overflow is allowed.
- TX:
  - Sends 2+NBITS symbols, each held BIT_CYCLES cycles.
  - Symbol order: preamble 1, preamble 0, then sample MSB first.
  - mod_out changes only on symbol boundaries. TX lasts (2+NBITS)*BIT_CYCLES cycles, then DONE.
- DONE:
  - done=1, busy=1, mod_out=0 for one cycle, then IDLE.
- abort:
  - Highest priority in every state. Go to IDLE at the next edge, all outputs except error forced low, no done pulse.
  - error is unchanged.
  - abort and scan_start together in IDLE: stay IDLE.
- scan_start while busy: ignored; latched_id is unchanged.
- sample_valid outside SAMPLE: ignored.
- node_id changes after latch: no effect until the next accepted scan_start.
- error: stays set until the next accepted scan_start.
- Reset mid-operation: asynchronous return to reset values.

Test Plan:
- Nominal, defaults, node_id=0, sample_valid returned 3 cycles after sample_req rises, sample_data=0xA5:
  - sense_en high 16+3 cycles.
  - SLOT_WAIT 1 cycle.
  - mod_out = 1,0,1,0,1,0,0,1,0,1, each 4 cycles.
  - done pulses once, 40 cycles after TX entry.
  - busy then low.
- Slot offset, node_id=3, sample 0xFF: gap from sample capture to TX entry is exactly 96 cycles; mod_out = 1,0 then eight 1s.
- Timeout: no sample_valid for 64 cycles in SAMPLE -> error=1, return to IDLE, done never pulses. The next scan_start clears error.
- Abort mid-TX (after 3 symbols) -> all outputs 0 at the next edge except error, no done. A following scan_start runs a full nominal cycle.
- Busy filtering: scan_start pulses during SETTLE and TX with node_id changed to 5 -> ignored, slot offset still uses the originally latched id.
- Async reset: rst_n low mid-SAMPLE, between clock edges -> all outputs 0 immediately, without waiting for a clock edge. After release, scan_start starts a clean cycle.

Source files
------------

// File: rtl/scan_slot_scheduler_if.sv
// Bundle of command-FSM and sensor/backscatter front-end signals seen by
// the scan slot scheduler. The scheduler connects through the slave view;
// the environment driving it (command FSM, ADC, modulator) uses master.
interface scan_slot_scheduler_if #(
  parameter int ID_WIDTH = 4,
  parameter int NBITS    = 8
) ();
  logic                scan_start;
  logic [ID_WIDTH-1:0] node_id;
  logic                abort;
  logic [NBITS-1:0]    sample_data;
  logic                sample_valid;
  logic                sense_en;
  logic                sample_req;
  logic                mod_out;
  logic                busy;
  logic                done;
  logic                error;

  modport slave (
    input  scan_start, node_id, abort, sample_data, sample_valid,
    output sense_en, sample_req, mod_out, busy, done, error
  );

  modport master (
    output scan_start, node_id, abort, sample_data, sample_valid,
    input  sense_en, sample_req, mod_out, busy, done, error
  );
endinterface

// File: rtl/scan_slot_scheduler.sv
// One sense-and-uplink cycle per accepted scan_start: power the front-end
// for a settle time, take one ADC sample, wait the node's TDMA slot, then
// send preamble "10" followed by the sample MSB first on mod_out.
// Every output is a register updated by the state machine below.
module scan_slot_scheduler #(
  parameter int SETTLE_CYCLES  = 16,
  parameter int SAMPLE_TIMEOUT = 64,
  parameter int SLOT_CYCLES    = 32,
  parameter int ID_WIDTH       = 4,
  parameter int NBITS          = 8,
  parameter int BIT_CYCLES     = 4
) (
  input  logic                 CLK_IN,
  input  logic                 rst_n,
  scan_slot_scheduler_if.slave bus
);

  // Slot counter is wide enough for (2^ID_WIDTH - 1) * SLOT_CYCLES.
  localparam int SW     = ID_WIDTH + $clog2(SLOT_CYCLES + 1);
  // One shared cycle counter serves SETTLE, SAMPLE and the TX bit timer.
  localparam int CMAX_A = (SETTLE_CYCLES > SAMPLE_TIMEOUT) ? SETTLE_CYCLES : SAMPLE_TIMEOUT;
  localparam int CMAX   = (CMAX_A > BIT_CYCLES) ? CMAX_A : BIT_CYCLES;
  localparam int CW     = $clog2(CMAX + 1);
  localparam int YW     = $clog2(NBITS + 2);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETTLE,
    S_SAMPLE,
    S_SLOT_WAIT,
    S_TX,
    S_DONE
  } state_t;

  state_t              state_q;
  logic [ID_WIDTH-1:0] id_q;
  logic [CW-1:0]       cnt_q;
  logic [SW-1:0]       slot_cnt_q;
  logic [YW-1:0]       sym_q;
  logic [NBITS-1:0]    shreg_q;
  logic                sense_en_q;
  logic                sample_req_q;
  logic                mod_out_q;
  logic                busy_q;
  logic                done_q;
  logic                error_q;

  logic [SW-1:0]       slot_prod;
  logic [SW-1:0]       slot_len;

  // Slot wait length: id * SLOT_CYCLES, but at least one cycle so node 0
  // still passes through SLOT_WAIT.
  assign slot_prod = SW'(id_q) * SW'(SLOT_CYCLES);
  assign slot_len  = (slot_prod == '0) ? SW'(1) : slot_prod;

  assign bus.sense_en   = sense_en_q;
  assign bus.sample_req = sample_req_q;
  assign bus.mod_out    = mod_out_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.error      = error_q;

  // Scheduler state machine with registered Moore outputs; abort overrides all states.
  always_ff @(posedge CLK_IN or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      id_q         <= '0;
      cnt_q        <= '0;
      slot_cnt_q   <= '0;
      sym_q        <= '0;
      shreg_q      <= '0;
      sense_en_q   <= 1'b0;
      sample_req_q <= 1'b0;
      mod_out_q    <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      error_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (bus.abort) begin
        // error is deliberately left alone so a timeout stays visible
        state_q      <= S_IDLE;
        cnt_q        <= '0;
        slot_cnt_q   <= '0;
        sym_q        <= '0;
        sense_en_q   <= 1'b0;
        sample_req_q <= 1'b0;
        mod_out_q    <= 1'b0;
        busy_q       <= 1'b0;
      end else begin
        unique case (state_q)
          S_IDLE: begin
            if (bus.scan_start) begin
              id_q       <= bus.node_id;
              error_q    <= 1'b0;
              cnt_q      <= '0;
              sense_en_q <= 1'b1;
              busy_q     <= 1'b1;
              state_q    <= S_SETTLE;
            end
          end

          S_SETTLE: begin
            if (cnt_q == CW'(SETTLE_CYCLES - 1)) begin
              cnt_q        <= '0;
              sample_req_q <= 1'b1;
              state_q      <= S_SAMPLE;
            end else begin
              cnt_q <= cnt_q + CW'(1);
            end
          end

          S_SAMPLE: begin
            // A sample arriving on the last allowed edge still wins over timeout.
            if (bus.sample_valid) begin
              shreg_q      <= bus.sample_data;
              slot_cnt_q   <= '0;
              sense_en_q   <= 1'b0;
              sample_req_q <= 1'b0;
              state_q      <= S_SLOT_WAIT;
            end else if (cnt_q == CW'(SAMPLE_TIMEOUT - 1)) begin
              cnt_q        <= '0;
              error_q      <= 1'b1;
              sense_en_q   <= 1'b0;
              sample_req_q <= 1'b0;
              busy_q       <= 1'b0;
              state_q      <= S_IDLE;
            end else begin
              cnt_q <= cnt_q + CW'(1);
            end
          end

          S_SLOT_WAIT: begin
            if (slot_cnt_q == slot_len - SW'(1)) begin
              slot_cnt_q <= '0;
              cnt_q      <= '0;
              sym_q      <= '0;
              mod_out_q  <= 1'b1;  // first preamble symbol
              state_q    <= S_TX;
            end else begin
              slot_cnt_q <= slot_cnt_q + SW'(1);
            end
          end

          S_TX: begin
            if (cnt_q == CW'(BIT_CYCLES - 1)) begin
              cnt_q <= '0;
              if (sym_q == YW'(NBITS + 1)) begin
                mod_out_q <= 1'b0;
                done_q    <= 1'b1;
                state_q   <= S_DONE;
              end else begin
                sym_q <= sym_q + YW'(1);
                if (sym_q == '0) begin
                  mod_out_q <= 1'b0;  // second preamble symbol
                end else begin
                  mod_out_q <= shreg_q[NBITS-1];
                  shreg_q   <= {shreg_q[NBITS-2:0], 1'b0};
                end
              end
            end else begin
              cnt_q <= cnt_q + CW'(1);
            end
          end

          S_DONE: begin
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end

          default: begin
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_scan_slot_scheduler.sv
// Randomized bench for scan_slot_scheduler. The reference model describes
// each scan cycle as a set of time intervals measured from the accepting
// edge and derives the expected outputs for every cycle from them.
module tb_scan_slot_scheduler;
  localparam int S    = 16;
  localparam int T    = 64;
  localparam int SLOT = 32;
  localparam int IDW  = 4;
  localparam int NB   = 8;
  localparam int B    = 4;

  logic CLK_IN = 1'b0;
  logic rst_n  = 1'b0;
  always #5 CLK_IN = ~CLK_IN;

  scan_slot_scheduler_if #(.ID_WIDTH(IDW), .NBITS(NB)) bus ();

  scan_slot_scheduler #(
    .SETTLE_CYCLES(S), .SAMPLE_TIMEOUT(T), .SLOT_CYCLES(SLOT),
    .ID_WIDTH(IDW), .NBITS(NB), .BIT_CYCLES(B)
  ) dut (
    .CLK_IN(CLK_IN),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // {sense_en, sample_req, mod_out, busy, done, error}
  wire [5:0] obs = {bus.sense_en, bus.sample_req, bus.mod_out, bus.busy, bus.done, bus.error};

  int   checks    = 0;
  int   errors    = 0;
  logic err_model = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got=%0h want=%0h", tag, got, want);
    end
  endtask

  // Offset (from the accepting edge) of the edge that ends SAMPLE.
  function automatic int samp_end_f(input int lat);
    return (lat > 0) ? S + lat : S + T;
  endfunction

  // Last offset at which busy is high (DONE cycle, or last SAMPLE cycle on timeout).
  function automatic int last_f(input int id, input int lat);
    int l;
    l = id * SLOT;
    if (l < 1) l = 1;
    return (lat > 0) ? samp_end_f(lat) + l + (NB + 2) * B : samp_end_f(lat) - 1;
  endfunction

  // Expected outputs at offset t; lat=0 means no sample arrives, ab=0 means no abort.
  function automatic logic [5:0] expect_at(input int t, input int id, input logic [NB-1:0] smp,
                                           input int lat, input int ab);
    int se_end, last, ts, k;
    logic se, rq, md, bz, dn, er;
    se_end = samp_end_f(lat);
    last   = last_f(id, lat);
    ts     = last - (NB + 2) * B;
    se = (t < se_end);
    rq = (t >= S) && (t < se_end);
    bz = (t <= last);
    dn = (lat > 0) && (t == last);
    md = 1'b0;
    if (lat > 0 && t >= ts && t < last) begin
      k = (t - ts) / B;
      if (k == 0)      md = 1'b1;
      else if (k == 1) md = 1'b0;
      else             md = smp[NB - 1 - (k - 2)];
    end
    er = (lat == 0) && (t >= se_end) && (ab == 0 || ab > se_end);
    if (ab > 0 && t >= ab) {se, rq, md, bz, dn} = 5'b0;
    return {se, rq, md, bz, dn, er};
  endfunction

  // One scan cycle: accept at E0, then check every cycle and drive inputs for the next edge.
  task automatic run_txn(input int n, input int id, input int lat, input int ab,
                         input int noise_pct, input int smp_force);
    logic [NB-1:0] smp;
    logic [5:0]    e;
    logic          insample;
    int            end_t;
    smp = '0;
    check($sformatf("txn%0d idle", n), obs, {5'b0, err_model});
    bus.node_id    = IDW'(id);
    bus.scan_start = 1'b1;
    @(posedge CLK_IN);
    @(negedge CLK_IN);
    bus.scan_start = 1'b0;
    if (ab > 0)       end_t = ab + 1;
    else if (lat > 0) end_t = last_f(id, lat) + 1;
    else              end_t = samp_end_f(lat) + 1;
    for (int t = 0; t <= end_t; t++) begin
      e = expect_at(t, id, smp, lat, ab);
      check($sformatf("txn%0d id%0d lat%0d ab%0d t%0d", n, id, lat, ab, t), obs, e);
      insample = (t >= S) && (t < samp_end_f(lat)) && (ab == 0 || t < ab);
      bus.sample_data = NB'($urandom);
      if (insample) bus.sample_valid = (lat > 0) && (t + 1 == S + lat);
      else          bus.sample_valid = ($urandom_range(0, 3) == 0);
      if (insample && bus.sample_valid) begin
        if (smp_force >= 0) bus.sample_data = NB'(smp_force);
        smp = bus.sample_data;
      end
      bus.abort      = (t + 1 == ab);
      bus.scan_start = e[2] && ($urandom_range(0, 99) < noise_pct);
      bus.node_id    = (noise_pct > 0) ? IDW'(5) : IDW'($urandom);
      @(negedge CLK_IN);
    end
    bus.scan_start   = 1'b0;
    bus.abort        = 1'b0;
    bus.sample_valid = 1'b0;
    e = expect_at(end_t + 1, id, smp, lat, ab);
    err_model = e[0];
  endtask

  initial begin
    int id, lat, ab, n;
    bus.scan_start   = 1'b0;
    bus.node_id      = '0;
    bus.abort        = 1'b0;
    bus.sample_data  = '0;
    bus.sample_valid = 1'b0;
    repeat (3) @(negedge CLK_IN);
    check("reset_state", obs, 6'b0);
    rst_n = 1'b1;
    @(negedge CLK_IN);
    check("after_reset", obs, 6'b0);

    n = 0;
    run_txn(n++, 0, 3, 0, 0, 'hA5);   // nominal
    run_txn(n++, 3, 3, 0, 0, 'hFF);   // slot offset
    run_txn(n++, 2, 0, 0, 0, -1);     // sample timeout
    run_txn(n++, 1, 5, 0, 0, -1);     // clears error
    run_txn(n++, 0, 3, 32, 0, -1);    // abort after 3 TX symbols
    run_txn(n++, 0, 3, 0, 0, 'hA5);   // full cycle after abort
    run_txn(n++, 2, 4, 0, 30, -1);    // scan_start noise with node_id=5
    run_txn(n++, 1, 64, 0, 0, -1);    // sample on the very last SAMPLE edge
    run_txn(n++, 1, 0, S + T, 0, -1); // abort on the timeout edge: no error
    run_txn(n++, 1, 0, 0, 0, -1);     // timeout then abort+scan_start in IDLE

    bus.abort = 1'b1;
    bus.scan_start = 1'b1;
    @(negedge CLK_IN);
    bus.abort = 1'b0;
    bus.scan_start = 1'b0;
    check("abort_and_start_idle", obs, {5'b0, err_model});
    @(negedge CLK_IN);
    check("abort_and_start_idle2", obs, {5'b0, err_model});

    // Asynchronous reset in the middle of SAMPLE
    bus.node_id = 4'd1;
    bus.scan_start = 1'b1;
    @(posedge CLK_IN);
    @(negedge CLK_IN);
    bus.scan_start = 1'b0;
    repeat (S + 1) @(negedge CLK_IN);
    check("pre_async_rst", obs, 6'b110100);
    #2 rst_n = 1'b0;
    #1 check("async_rst", obs, 6'b0);
    @(negedge CLK_IN);
    rst_n = 1'b1;
    err_model = 1'b0;
    @(negedge CLK_IN);
    run_txn(n++, 0, 3, 0, 0, 'hA5);

    for (int i = 0; i < 25; i++) begin
      id  = $urandom_range(0, 15);
      lat = ($urandom_range(0, 5) == 0) ? 0 : $urandom_range(1, T);
      ab  = ($urandom_range(0, 3) == 0) ? $urandom_range(1, last_f(id, lat)) : 0;
      run_txn(n++, id, lat, ab, 20, -1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
